// File: rtl/sram_req_ctrl_pkg.sv
// Shared widths, depth and read-response payload for the 1RW array request controller.
package sram_req_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 3072;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rresp_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(DEPTH));
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry read-response buffer; push and pop may coincide even when full.
module sram_resp_fifo
  import sram_req_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  rresp_t     i_push_data,
  input  logic       i_pop,
  output rresp_t     o_head,
  output logic [1:0] o_count
);

  rresp_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Entry storage, ring pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Arbitrates write/read request streams onto the single RW port of the 3072x32 array.
// Optional SRAM_REQ_CTRL_RR_ARB_EN selects round-robin instead of fixed write priority.
module sram_1rw_req_ctrl
  import sram_req_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [DATA_W-1:0] wreq_data,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  output logic              rresp_valid,
  input  logic              rresp_ready,
  output logic [DATA_W-1:0] rresp_data,
  output logic              rresp_err,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic       w_pop;
  logic [1:0] w_fifo_count;
  logic [2:0] w_credit_used;
  logic       w_rd_elig;
  logic       w_wr_req;
  logic       w_rd_req;
  logic       w_wr_gnt;
  logic       w_rd_gnt;
  logic       w_wr_in_range;
  logic       w_rd_in_range;
  logic       r_inflight;
  logic       r_trk_err;
  rresp_t     w_head;
  rresp_t     w_push_data;

  // A read may issue only if its response is guaranteed a buffer slot
  assign w_pop         = rresp_valid & rresp_ready;
  assign w_credit_used = {2'b00, r_inflight} + {1'b0, w_fifo_count} - {2'b00, w_pop};
  assign w_rd_elig     = (w_credit_used < 3'd2);
  assign w_wr_req      = wreq_valid & ~reset;
  assign w_rd_req      = rreq_valid & w_rd_elig & ~reset;
  assign w_wr_in_range = addr_in_range(wreq_addr);
  assign w_rd_in_range = addr_in_range(rreq_addr);

`ifdef SRAM_REQ_CTRL_RR_ARB_EN
  logic r_prio_rd;

  // Priority pointer: the stream granted last yields to the other
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prio_rd <= 1'b0;
    end else if (w_wr_gnt) begin
      r_prio_rd <= 1'b1;
    end else if (w_rd_gnt) begin
      r_prio_rd <= 1'b0;
    end
  end

  assign w_wr_gnt = w_wr_req & ~(w_rd_req & r_prio_rd);
  assign w_rd_gnt = w_rd_req & ~w_wr_gnt;
`else
  assign w_wr_gnt = w_wr_req;
  assign w_rd_gnt = w_rd_req & ~w_wr_req;
`endif

  assign wreq_ready = w_wr_gnt;
  assign rreq_ready = w_rd_gnt;

  // Array port: out-of-range accesses are accepted but leave the array idle
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_wr_gnt && w_wr_in_range) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wreq_addr;
      sram_wdata = wreq_data;
    end else if (w_rd_gnt && w_rd_in_range) begin
      sram_en    = 1'b1;
      sram_addr  = rreq_addr;
    end else begin
      sram_en    = 1'b0;
    end
  end

  // One-cycle tracker matching the array read latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_trk_err  <= 1'b0;
    end else begin
      r_inflight <= w_rd_gnt;
      r_trk_err  <= w_rd_gnt & ~w_rd_in_range;
    end
  end

  assign w_push_data.data = r_trk_err ? '0 : sram_rdata;
  assign w_push_data.err  = r_trk_err;

  sram_resp_fifo u_resp_fifo (
    .clk         (clock),
    .rst         (reset),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_count)
  );

  assign rresp_valid = (w_fifo_count != 2'd0);
  assign rresp_data  = rresp_valid ? w_head.data : '0;
  assign rresp_err   = rresp_valid & w_head.err;

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Self-checking bench: behavioural array, shadow-memory/response-queue model, directed and random steps.
`timescale 1ns/1ps
module tb_sram_1rw_req_ctrl;
  import sram_req_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              wreq_valid, wreq_ready, rreq_valid, rreq_ready;
  logic [ADDR_W-1:0] wreq_addr, rreq_addr, sram_addr;
  logic [DATA_W-1:0] wreq_data, rresp_data, sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              rresp_valid, rresp_ready, rresp_err, sram_en, sram_wmode;

  sram_1rw_req_ctrl dut (
    .clock(clock), .reset(reset),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
    .rresp_valid(rresp_valid), .rresp_ready(rresp_ready), .rresp_data(rresp_data), .rresp_err(rresp_err),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] sram_mem [0:4095];

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= sram_mem[sram_addr];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:4095];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_no = 0;
  int          n_resp = 0;
  int          last_resp_cyc = 0;
  logic        last_wr = 1'b0;
  logic        s_wready, s_rready, s_en, s_rvalid, s_rerr;
  logic [31:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic wv, input int wa, input logic [31:0] wd,
                        input logic rv, input int ra, input logic rr);
    wreq_valid  = wv;
    wreq_addr   = 12'(wa);
    wreq_data   = wd;
    rreq_valid  = rv;
    rreq_addr   = 12'(ra);
    rresp_ready = rr;
  endtask

  // One clock: sample mid-cycle, compare against the model, advance the model, step past the edge.
  task automatic cyc();
    logic e_v, pop, r_ok, e_w, e_r, w_in, r_in;
    exp_t e;
    @(negedge clock);
    s_wready = wreq_ready; s_rready = rreq_ready; s_en = sram_en;
    s_rvalid = rresp_valid; s_rdata = rresp_data; s_rerr = rresp_err;
    if (reset) begin
      exp_q.delete();
      last_wr = 1'b0;
    end
    e_v  = (exp_q.size() > 0) && (exp_q[0].acc <= cyc_no - 2);
    pop  = e_v & rresp_ready;
    r_ok = (exp_q.size() - int'(pop)) < 2;
    e_w  = wreq_valid & ~reset;
    e_r  = rreq_valid & r_ok & ~reset;
`ifdef SRAM_REQ_CTRL_RR_ARB_EN
    if (e_w && e_r) begin
      if (last_wr) e_w = 1'b0;
      else         e_r = 1'b0;
    end
`else
    if (e_w) e_r = 1'b0;
`endif
    w_in = int'(wreq_addr) < DEPTH;
    r_in = int'(rreq_addr) < DEPTH;
    chk("wreq_ready", wreq_ready, e_w);
    chk("rreq_ready", rreq_ready, e_r);
    chk("rresp_valid", rresp_valid, e_v);
    if (e_v) begin
      chk("rresp_data", rresp_data, exp_q[0].data);
      chk("rresp_err", rresp_err, exp_q[0].err);
    end
    if (e_w && w_in) begin
      chk("sram_en_w", sram_en, 1'b1);
      chk("sram_wmode_w", sram_wmode, 1'b1);
      chk("sram_addr_w", sram_addr, wreq_addr);
      chk("sram_wdata_w", sram_wdata, wreq_data);
    end else if (e_r && r_in) begin
      chk("sram_en_r", sram_en, 1'b1);
      chk("sram_wmode_r", sram_wmode, 1'b0);
      chk("sram_addr_r", sram_addr, rreq_addr);
    end else begin
      chk("sram_en_idle", sram_en, 1'b0);
      chk("sram_wmode_idle", sram_wmode, 1'b0);
      chk("sram_addr_idle", sram_addr, 12'd0);
      chk("sram_wdata_idle", sram_wdata, 32'd0);
    end
    if (pop) begin
      void'(exp_q.pop_front());
      n_resp++;
      last_resp_cyc = cyc_no;
    end
    if (e_w) begin
      if (w_in) ref_mem[wreq_addr] = wreq_data;
      last_wr = 1'b1;
    end
    if (e_r) begin
      e.data = r_in ? ref_mem[rreq_addr] : 32'd0;
      e.err  = ~r_in;
      e.acc  = cyc_no;
      exp_q.push_back(e);
      last_wr = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc_no++;
  endtask

  initial begin
    int first_acc;
    int n_acc;
    logic prev_w;
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = 32'd0;
      ref_mem[i]  = 32'd0;
    end

    // Reset: grants suppressed even with both requests valid
    reset = 1'b1;
    set_in(1'b1, 3, 32'h1, 1'b1, 4, 1'b1);
    cyc();
    cyc();
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_rready", s_rready, 1'b0);
    chk("rst_sram_en", s_en, 1'b0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_rerr", s_rerr, 1'b0);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    reset = 1'b0;
    cyc();

    // Write then read, response exactly two cycles after the handshake
    set_in(1'b1, 12'h0A5, 32'hDEADBEEF, 1'b0, 0, 1'b1);
    cyc();
    chk("wr_a5_ready", s_wready, 1'b1);
    chk("wr_a5_en", s_en, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b1, 12'h0A5, 1'b1);
    cyc();
    chk("rd_a5_ready", s_rready, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    cyc();
    chk("rd_a5_t1_valid", s_rvalid, 1'b0);
    cyc();
    chk("rd_a5_t2_valid", s_rvalid, 1'b1);
    chk("rd_a5_data", s_rdata, 32'hDEADBEEF);
    chk("rd_a5_err", s_rerr, 1'b0);
    cyc();

    // Simultaneous write and read to the same address
    set_in(1'b1, 12'h010, 32'h1234, 1'b1, 12'h010, 1'b1);
`ifdef SRAM_REQ_CTRL_RR_ARB_EN
    cyc();
    prev_w = s_wready;
    chk("rr_one_grant", s_wready ^ s_rready, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("rr_alternate", s_wready, ~prev_w);
      chk("rr_one_grant", s_wready ^ s_rready, 1'b1);
      prev_w = s_wready;
    end
`else
    cyc();
    chk("same_wr_first", s_wready, 1'b1);
    chk("same_rd_held", s_rready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("fixed_starve", s_rready, 1'b0);
    end
    set_in(1'b0, 0, 32'd0, 1'b1, 12'h010, 1'b1);
    cyc();
    chk("same_rd_next", s_rready, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    cyc();
    cyc();
    chk("same_rd_valid", s_rvalid, 1'b1);
    chk("same_rd_data", s_rdata, 32'h1234);
`endif
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cyc();

    // Backpressure: only two reads accepted while the consumer stalls
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, i, 32'hB000_0000 + 32'(i), 1'b0, 0, 1'b1);
      cyc();
    end
    set_in(1'b0, 0, 32'd0, 1'b1, 0, 1'b0);
    cyc();
    chk("bp_rd0", s_rready, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b1, 1, 1'b0);
    cyc();
    chk("bp_rd1", s_rready, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_rd2_blocked", s_rready, 1'b0);
    end
    set_in(1'b0, 0, 32'd0, 1'b1, 2, 1'b1);
    cyc();
    chk("bp_rd2_on_release", s_rready, 1'b1);
    chk("bp_resp0", s_rdata, 32'hB000_0000);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    cyc();
    chk("bp_resp1", s_rdata, 32'hB000_0001);
    cyc();
    chk("bp_resp2_valid", s_rvalid, 1'b1);
    chk("bp_resp2", s_rdata, 32'hB000_0002);
    cyc();

    // Out-of-range read and write
    set_in(1'b0, 0, 32'd0, 1'b1, 3072, 1'b1);
    cyc();
    chk("oor_rd_ready", s_rready, 1'b1);
    chk("oor_rd_no_en", s_en, 1'b0);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    cyc();
    chk("oor_rd_t1_no_en", s_en, 1'b0);
    cyc();
    chk("oor_rd_valid", s_rvalid, 1'b1);
    chk("oor_rd_err", s_rerr, 1'b1);
    chk("oor_rd_data", s_rdata, 32'd0);
    set_in(1'b1, 4095, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
    cyc();
    chk("oor_wr_ready", s_wready, 1'b1);
    chk("oor_wr_no_en", s_en, 1'b0);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    cyc();

    // Streaming: 100 back-to-back reads complete in 102 cycles
    first_acc = cyc_no;
    n_acc = 0;
    n_resp = 0;
    for (int i = 0; i < 100; i++) begin
      set_in(1'b0, 0, 32'd0, 1'b1, $urandom_range(0, 3071), 1'b1);
      cyc();
      if (s_rready) n_acc++;
    end
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
    chk("stream_accepted", n_acc, 100);
    chk("stream_responses", n_resp, 100);
    chk("stream_span", last_resp_cyc - first_acc + 1, 102);

    // Reset with one read in flight and one response buffered
    set_in(1'b0, 0, 32'd0, 1'b1, 5, 1'b0);
    cyc();
    chk("rstmid_rd5", s_rready, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b1, 6, 1'b0);
    cyc();
    chk("rstmid_rd6", s_rready, 1'b1);
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    cyc();
    chk("rstmid_during", s_rvalid, 1'b0);
    rresp_ready = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rstmid_after", s_rvalid, 1'b0);
    end

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0) ? $urandom_range(3072, 4095) : $urandom_range(0, 15),
             $urandom,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? $urandom_range(3072, 4095) : $urandom_range(0, 15),
             1'($urandom_range(0, 9) < 7));
      cyc();
    end
    set_in(1'b0, 0, 32'd0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
    chk("random_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
